// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared constants, receiver FSM encoding and baud helper for
//               the 04_uart design.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

  // Parity mode selectors for P_PARITY_TYPE
  localparam int unsigned PARITY_NONE = 0;
  localparam int unsigned PARITY_ODD  = 1;
  localparam int unsigned PARITY_EVEN = 2;

  // Receiver FSM encoding
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } rx_state_e;

  // Clock cycles per bit period; a zero baud rate yields 0 so the
  // elaboration check in the user module rejects it.
  function automatic int unsigned calc_baud_div(input int unsigned clk_freq,
                                                input int unsigned baud);
    if (baud == 0) begin
      return 0;
    end
    return clk_freq / baud;
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx_sync.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_sync
// Description : Two-flop synchroniser for an asynchronous, idle-high line plus
//               a history flop giving a one-cycle falling-edge pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_sync (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_async,
  output logic o_sync,
  output logic o_fall
);

  logic       meta_q;
  logic       sync_q;
  logic       hist_q;
  // Edge detection is held off until the history flop carries a genuine line
  // sample; otherwise the reset value of 1 followed by a line that is low
  // (reset mid-frame, break) would look like a fresh start edge.
  logic [2:0] arm_q;

  // Synchroniser chain, history flop and post-reset arming shift register
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      hist_q <= 1'b1;
      arm_q  <= 3'b000;
    end else begin
      meta_q <= i_async;
      sync_q <= meta_q;
      hist_q <= sync_q;
      arm_q  <= {arm_q[1:0], 1'b1};
    end
  end

  assign o_sync = sync_q;
  assign o_fall = arm_q[2] & hist_q & ~sync_q;

endmodule
`default_nettype wire

// File: rtl/uart_rx_module.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_module
// Description : UART receiver. Deserialises i_uart_rx (LSB first), checks
//               optional parity and stop bits, and presents each word with a
//               one-cycle valid pulse and error flags qualified by valid.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_module #(
  parameter int unsigned P_CLK_FREQ      = 50000000,
  parameter int unsigned P_UART_BAUDRATE = 115200,
  parameter int unsigned P_DATA_WIDTH    = 8,
  parameter int unsigned P_PARITY_TYPE   = 0,
  parameter int unsigned P_STOP_WIDTH    = 1
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_uart_rx,
  output logic [P_DATA_WIDTH-1:0] o_user_rx_data,
  output logic                    o_user_rx_valid,
  output logic                    o_parity_err,
  output logic                    o_frame_err
);

  import uart_pkg::*;

  localparam int unsigned BAUD_DIV = calc_baud_div(P_CLK_FREQ, P_UART_BAUDRATE);
  localparam int unsigned HALF     = BAUD_DIV / 2;
  localparam int unsigned CNT_W    = (BAUD_DIV > 4) ? $clog2(BAUD_DIV) : 2;

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(BAUD_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_HALF  = CNT_W'(HALF - 1);
  localparam logic [3:0]       DATA_LAST = 4'(P_DATA_WIDTH - 1);
  localparam logic [3:0]       STOP_LAST = 4'(P_STOP_WIDTH - 1);
  localparam logic             PAR_EN    = (P_PARITY_TYPE != PARITY_NONE);
  localparam logic             PAR_ODD   = (P_PARITY_TYPE == PARITY_ODD);

  // Reject parameter sets the datapath cannot honour
  if (BAUD_DIV < 4) begin : g_bad_baud
    $error("uart_rx_module: BAUD_DIV must be at least 4");
  end
  if (P_DATA_WIDTH < 5 || P_DATA_WIDTH > 8) begin : g_bad_width
    $error("uart_rx_module: P_DATA_WIDTH must be 5..8");
  end
  if (P_PARITY_TYPE > PARITY_EVEN) begin : g_bad_parity
    $error("uart_rx_module: P_PARITY_TYPE must be 0, 1 or 2");
  end
  if (P_STOP_WIDTH < 1 || P_STOP_WIDTH > 2) begin : g_bad_stop
    $error("uart_rx_module: P_STOP_WIDTH must be 1 or 2");
  end

  logic rx_line;
  logic rx_fall;

  uart_rx_sync u_sync (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_async (i_uart_rx),
    .o_sync  (rx_line),
    .o_fall  (rx_fall)
  );

  rx_state_e               state_q,     state_d;
  logic [CNT_W-1:0]        cnt_q,       cnt_d;
  logic [3:0]              bit_cnt_q,   bit_cnt_d;
  logic [P_DATA_WIDTH-1:0] shift_q,     shift_d;
  logic                    perr_flag_q, perr_flag_d;
  logic                    ferr_flag_q, ferr_flag_d;
  logic                    done_q,      done_d;

  logic [P_DATA_WIDTH-1:0] data_q;
  logic                    valid_q;
  logic                    perr_q;
  logic                    ferr_q;

  // Frame FSM state, baud/bit counters, shift register and sticky error flags
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      perr_flag_q <= 1'b0;
      ferr_flag_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      perr_flag_q <= perr_flag_d;
      ferr_flag_q <= ferr_flag_d;
      done_q      <= done_d;
    end
  end

  // Next-state logic: every transition clears the baud counter so each
  // state times its sample point from its own entry.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    // Sticky flags are handed to the output stage by done_q, then cleared
    perr_flag_d = done_q ? 1'b0 : perr_flag_q;
    ferr_flag_d = done_q ? 1'b0 : ferr_flag_q;
    done_d      = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        cnt_d     = '0;
        bit_cnt_d = '0;
        if (rx_fall) begin
          state_d = ST_START;
        end
      end

      ST_START: begin
        if (cnt_q == CNT_HALF) begin
          cnt_d   = '0;
          // Line back high at mid-start means a glitch, not a frame
          state_d = rx_line ? ST_IDLE : ST_DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_DATA: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          // Shift in from the top; after P_DATA_WIDTH samples bit 0 is LSB
          shift_d = {rx_line, shift_q[P_DATA_WIDTH-1:1]};
          if (bit_cnt_q == DATA_LAST) begin
            bit_cnt_d = '0;
            state_d   = PAR_EN ? ST_PARITY : ST_STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_PARITY: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = ST_STOP;
          if (((^shift_q) ^ rx_line) != PAR_ODD) begin
            perr_flag_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_STOP: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          if (!rx_line) begin
            ferr_flag_d = 1'b1;
          end
          // Leaving at mid-stop lets the next start edge follow immediately
          if (bit_cnt_q == STOP_LAST) begin
            bit_cnt_d = '0;
            state_d   = ST_IDLE;
            done_d    = 1'b1;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output register: data holds between words, error flags live only with valid
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      valid_q <= done_q;
      perr_q  <= done_q & perr_flag_q;
      ferr_q  <= done_q & ferr_flag_q;
      if (done_q) begin
        data_q <= shift_q;
      end
    end
  end

  assign o_user_rx_data  = data_q;
  assign o_user_rx_valid = valid_q;
  assign o_parity_err    = perr_q;
  assign o_frame_err     = ferr_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_module.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_rx_module
// Description : Scoreboard bench for uart_rx_module. Three receivers with
//               BAUD_DIV = 16: no parity/1 stop, even parity/1 stop and
//               no parity/2 stop. Expected words are queued as frames are
//               driven and compared when each receiver raises valid.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx_module;

  localparam int BIT_T   = 16;
  localparam int LAT_EXP = 3 + 8 + 9 * 16 + 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rx0 = 1'b1;
  logic rx1 = 1'b1;
  logic rx2 = 1'b1;

  logic [7:0] d0, d1, d2;
  logic       v0, v1, v2;
  logic       pe0, pe1, pe2;
  logic       fe0, fe1, fe2;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;

  typedef struct packed {
    logic [7:0]  data;
    logic        perr;
    logic        ferr;
    logic        chk_lat;
    logic [31:0] t0;
  } exp_t;

  exp_t sb0[$];
  exp_t sb1[$];
  exp_t sb2[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_rx_module #(.P_CLK_FREQ(160), .P_UART_BAUDRATE(10), .P_DATA_WIDTH(8),
                   .P_PARITY_TYPE(0), .P_STOP_WIDTH(1)) u_dut0 (
    .i_clk(clk), .i_rst(rst), .i_uart_rx(rx0), .o_user_rx_data(d0),
    .o_user_rx_valid(v0), .o_parity_err(pe0), .o_frame_err(fe0));

  uart_rx_module #(.P_CLK_FREQ(160), .P_UART_BAUDRATE(10), .P_DATA_WIDTH(8),
                   .P_PARITY_TYPE(2), .P_STOP_WIDTH(1)) u_dut1 (
    .i_clk(clk), .i_rst(rst), .i_uart_rx(rx1), .o_user_rx_data(d1),
    .o_user_rx_valid(v1), .o_parity_err(pe1), .o_frame_err(fe1));

  uart_rx_module #(.P_CLK_FREQ(160), .P_UART_BAUDRATE(10), .P_DATA_WIDTH(8),
                   .P_PARITY_TYPE(0), .P_STOP_WIDTH(2)) u_dut2 (
    .i_clk(clk), .i_rst(rst), .i_uart_rx(rx2), .o_user_rx_data(d2),
    .o_user_rx_valid(v2), .o_parity_err(pe2), .o_frame_err(fe2));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_word(input string who, input exp_t e, input logic [7:0] d,
                            input logic pe, input logic fe);
    chk({who, "_data"}, 32'(d), 32'(e.data));
    chk({who, "_parity_err"}, 32'(pe), 32'(e.perr));
    chk({who, "_frame_err"}, 32'(fe), 32'(e.ferr));
    if (e.chk_lat) begin
      chk({who, "_latency"}, 32'(cyc) - e.t0, 32'(LAT_EXP));
    end
  endtask

  // Per-receiver monitors: pop on valid, check flags drop right after valid
  logic pv0 = 1'b0, pv1 = 1'b0, pv2 = 1'b0;

  always @(negedge clk) begin
    if (v0) begin
      if (sb0.size() == 0) chk("dut0_unexpected_valid", 32'd1, 32'd0);
      else check_word("dut0", sb0.pop_front(), d0, pe0, fe0);
    end else if (pv0) begin
      chk("dut0_flag_hold", {30'd0, pe0, fe0}, 32'd0);
    end
    pv0 <= v0;
  end

  always @(negedge clk) begin
    if (v1) begin
      if (sb1.size() == 0) chk("dut1_unexpected_valid", 32'd1, 32'd0);
      else check_word("dut1", sb1.pop_front(), d1, pe1, fe1);
    end else if (pv1) begin
      chk("dut1_flag_hold", {30'd0, pe1, fe1}, 32'd0);
    end
    pv1 <= v1;
  end

  always @(negedge clk) begin
    if (v2) begin
      if (sb2.size() == 0) chk("dut2_unexpected_valid", 32'd1, 32'd0);
      else check_word("dut2", sb2.pop_front(), d2, pe2, fe2);
    end else if (pv2) begin
      chk("dut2_flag_hold", {30'd0, pe2, fe2}, 32'd0);
    end
    pv2 <= v2;
  end

  function automatic int qsize(input int idx);
    case (idx)
      0:       return sb0.size();
      1:       return sb1.size();
      default: return sb2.size();
    endcase
  endfunction

  task automatic push(input int idx, input logic [7:0] d, input logic pe,
                      input logic fe, input logic lat);
    exp_t e;
    e.data = d; e.perr = pe; e.ferr = fe; e.chk_lat = lat; e.t0 = 32'(cyc);
    case (idx)
      0:       sb0.push_back(e);
      1:       sb1.push_back(e);
      default: sb2.push_back(e);
    endcase
  endtask

  task automatic drive_line(input int idx, input logic val);
    case (idx)
      0:       rx0 = val;
      1:       rx1 = val;
      default: rx2 = val;
    endcase
  endtask

  // Frame bits LSB first: start, 8 data bits, then tail (parity/stop bits)
  function automatic logic [15:0] mk(input logic [7:0] d, input logic [2:0] tail);
    return {4'b0000, tail, d, 1'b0};
  endfunction

  // Called at a falling clock edge; each bit is held for one bit period
  task automatic send_bits(input int idx, input logic [15:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      drive_line(idx, bits[i]);
      repeat (BIT_T) @(negedge clk);
    end
    drive_line(idx, 1'b1);
  endtask

  task automatic drain(input int idx, input int max_cyc);
    int n;
    n = 0;
    while (qsize(idx) != 0 && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    chk("drain_pending_words", 32'(qsize(idx)), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] pd;

    // Reset state (reset held for 10 cycles)
    rst = 1'b1;
    repeat (5) @(negedge clk);
    chk("reset_data", 32'(d0), 32'd0);
    chk("reset_valid", 32'(v0), 32'd0);
    chk("reset_parity_err", 32'(pe0), 32'd0);
    chk("reset_frame_err", 32'(fe0), 32'd0);
    repeat (5) @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);

    // Clean frame with exact latency
    push(0, 8'hA5, 1'b0, 1'b0, 1'b1);
    send_bits(0, mk(8'hA5, 3'b001), 10);
    drain(0, 200);
    repeat (20) @(negedge clk);

    // Glitch shorter than half a bit is rejected
    rx0 = 1'b0;
    repeat (4) @(negedge clk);
    rx0 = 1'b1;
    repeat (40) @(negedge clk);
    chk("glitch_back_to_idle", 32'(u_dut0.state_q), 32'd0);
    push(0, 8'h3C, 1'b0, 1'b0, 1'b0);
    send_bits(0, mk(8'h3C, 3'b001), 10);
    drain(0, 200);
    repeat (20) @(negedge clk);

    // Even parity: mismatch when XOR(data, parity bit) is 1
    pd = 8'h0F;
    push(1, pd, (^pd) ^ 1'b1, 1'b0, 1'b0);
    send_bits(1, mk(pd, 3'b011), 11);
    drain(1, 200);
    repeat (20) @(negedge clk);
    push(1, pd, (^pd) ^ 1'b0, 1'b0, 1'b0);
    send_bits(1, mk(pd, 3'b010), 11);
    drain(1, 200);
    repeat (20) @(negedge clk);

    // Framing error: stop bit low, then idle high, exactly one word expected
    push(0, 8'h55, 1'b0, 1'b1, 1'b0);
    send_bits(0, mk(8'h55, 3'b000), 10);
    drain(0, 200);
    repeat (200) @(negedge clk);

    // Back-to-back frames, 2 stop bits, no idle gap
    push(2, 8'h01, 1'b0, 1'b0, 1'b0);
    push(2, 8'h80, 1'b0, 1'b0, 1'b0);
    push(2, 8'hFF, 1'b0, 1'b0, 1'b0);
    send_bits(2, mk(8'h01, 3'b011), 11);
    send_bits(2, mk(8'h80, 3'b011), 11);
    send_bits(2, mk(8'hFF, 3'b011), 11);
    drain(2, 200);
    repeat (20) @(negedge clk);

    // One-cycle reset in the middle of data bit 4 discards the frame
    fork
      send_bits(0, mk(8'hC3, 3'b001), 10);
      begin
        repeat (BIT_T * 5 + 8) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midreset_data", 32'(d0), 32'd0);
        chk("midreset_valid", 32'(v0), 32'd0);
        chk("midreset_parity_err", 32'(pe0), 32'd0);
        chk("midreset_frame_err", 32'(fe0), 32'd0);
      end
    join
    repeat (100) @(negedge clk);
    push(0, 8'h5A, 1'b0, 1'b0, 1'b0);
    send_bits(0, mk(8'h5A, 3'b001), 10);
    drain(0, 200);
    repeat (50) @(negedge clk);

    chk("final_sb0_empty", 32'(sb0.size()), 32'd0);
    chk("final_sb1_empty", 32'(sb1.size()), 32'd0);
    chk("final_sb2_empty", 32'(sb2.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uart_rx_module.md
Name: uart_rx_module

Overview:
UART receiver for the 04_uart design. It sits downstream of the power-on reset generator and consumes that generator's active-high reset on i_rst. It deserialises the asynchronous i_uart_rx line into parallel words, flags parity and framing errors, and presents each word to user logic as a one-cycle valid pulse.

Parameters:
P_CLK_FREQ, 50000000, system clock frequency in Hz.
P_UART_BAUDRATE, 115200, line baud rate in bit/s.
P_DATA_WIDTH, 8, data bits per frame (5..8), sent LSB first.
P_PARITY_TYPE, 0, parity mode: 0 = none, 1 = odd, 2 = even.
P_STOP_WIDTH, 1, number of stop bits (1 or 2).

Ports:
i_clk  input  1  system clock; every register is clocked on its rising edge.
i_rst  input  1  synchronous, active-high reset; driven by the reset generator's o_rst.
i_uart_rx  input  1  asynchronous serial line; idles high.
o_user_rx_data  output  P_DATA_WIDTH  last received word; held until the next valid.
o_user_rx_valid  output  1  one-cycle pulse when a frame completes.
o_parity_err  output  1  parity mismatch for the current word; qualified by valid.
o_frame_err  output  1  a stop bit was sampled 0; qualified by valid.

Behaviour:
- Constants: BAUD_DIV = P_CLK_FREQ / P_UART_BAUDRATE (integer division). HALF = BAUD_DIV / 2.
- Elaboration: BAUD_DIV < 4 or an illegal parameter value raises an elaboration error.
- Reset values: data 0, valid 0, parity_err 0, frame_err 0, synchroniser flops 1, FSM in IDLE, bit counter 0, baud counter 0.
- Reset mid-frame: i_rst high forces all reset values on the next edge. The partial frame is discarded and no valid is issued.
- Input path: 2-FF synchroniser followed by one history flop. A start edge is synced-line 0 with previous value 1.
- Baud counter: counts 0..BAUD_DIV-1. It clears on every state entry.
- IDLE: on a start edge, go to START and clear the counter.
- START: sample at count HALF-1.
  - Sample 0: go to DATA and clear the counter.
  - Sample 1: false start; return to IDLE with no output.
- DATA: sample at count BAUD_DIV-1 and shift into bit position bit_cnt (LSB first).
  - After P_DATA_WIDTH samples, go to PARITY if parity is enabled, otherwise to STOP.
- PARITY: sample at count BAUD_DIV-1.
  - Odd parity requires XOR(data, parity bit) = 1.
  - Even parity requires XOR(data, parity bit) = 0.
  - A mismatch latches an internal parity error flag.
- STOP: sample at count BAUD_DIV-1, once per stop bit.
  - Any stop sample equal to 0 latches an internal frame error flag.
  - The last stop sample moves the FSM to IDLE in the same edge, i.e. at mid-stop. This allows back-to-back frames with no idle gap.
- Output timing: on the cycle after the last stop sample:
  - o_user_rx_valid = 1 for exactly one cycle;
  - data and both error flags update in that same cycle;
  - internal error flags clear.
- Errors are reported, not suppressed: valid still fires with error flags set.
- Flag hold: error outputs return to 0 when valid deasserts; data holds its value.
- A line held low after a frame (break) produces one frame_err word, then the receiver waits for a new 1→0 edge.
- Latency: valid asserts roughly (1 + P_DATA_WIDTH + parity + P_STOP_WIDTH - 0.5) × BAUD_DIV + 4 cycles after the line's falling edge, the 4 being 3 input-flop stages plus 1 output register. Exact count: 3 + HALF + (P_DATA_WIDTH + parity + P_STOP_WIDTH) × BAUD_DIV + 1.

Decomposition:
- Package uart_pkg:
  - parity constants PARITY_NONE = 0, PARITY_ODD = 1, PARITY_EVEN = 2;
  - FSM state encoding (IDLE, START, DATA, PARITY, STOP; 3 bits);
  - function calc_baud_div(clk, baud).
- Sub-module uart_rx_sync: 2-FF synchroniser plus falling-edge detect. Reset value 1; outputs the synced line and a one-cycle start-edge pulse. The transmitter reuses it later for CTS.

Test Plan:
Bench setup: P_CLK_FREQ = 160, P_UART_BAUDRATE = 10, so BAUD_DIV = 16. The reset generator drives i_rst for 10 cycles.
- Clean frame: send 0xA5, no parity, 1 stop → single valid pulse, data = 0xA5, parity_err = 0, frame_err = 0, at 3 + 8 + 9×16 + 1 = 156 cycles after the edge.
- Glitch: line low for 4 cycles, then high → no valid; FSM back in IDLE; a following 0x3C frame is received correctly.
- Even parity: send 0x0F with parity bit 1 → valid, data = 0x0F, parity_err = 1. Repeat with parity bit 0 → parity_err = 0.
- Framing error: send 0x55 with stop bit 0, then hold the line high → valid, data = 0x55, frame_err = 1, then no further valid.
- Back-to-back frames: send 0x01, 0x80, 0xFF with zero idle bits and 2 stop bits → three valids in order, all error flags 0.
- Reset mid-frame: assert i_rst for 1 cycle during data bit 4 of 0xC3 → no valid for that frame; all outputs 0; the next 0x5A frame is received correctly.
